rf_wr_ctrl: RTL and testbench

Write-port controller for the 2R1W register file. It clears registers 1..NREG-1 to zero after reset or on request. It then shares the single write port (we3/a3/wd3) between the core writeback path and a debug/loader port using valid/ready handshakes. Core has priority, with a starvation guard for debug. The outputs drive the register file write port directly, registered.

---
 rtl/rf_wr_ctrl.sv | 114 +++++++++++
 tb/tb_rf_wr_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_ctrl.sv
// rf_wr_ctrl: write-port controller for a 2R1W register file.
// After reset (or on clr_req) it clears registers 1..NREG-1 to zero. It then
// arbitrates the single write port between the core writeback path and a
// debug/loader port. Core has priority, and a starvation guard forces a
// debug grant after STARVE_LIM consecutive denied cycles.
module rf_wr_ctrl #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          core_valid,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wd,
  output logic          core_ready,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wd,
  output logic          dbg_ready,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  output logic          init_done
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] starve;

  logic          force_dbg;
  logic          core_go;
  logic          dbg_go;
  logic          go;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wd;
  logic          addr_ok;

  // Arbitration: ready flags, winner selection and write-address legality.
  always_comb begin
    force_dbg  = 1'b0;
    core_ready = 1'b0;
    dbg_ready  = 1'b0;
    if (state == RUN) begin
      force_dbg  = (starve == STARVE_MAX);
      core_ready = !force_dbg;
      dbg_ready  = force_dbg || !core_valid;
    end
    core_go  = core_valid && core_ready;
    dbg_go   = dbg_valid && dbg_ready;
    go       = core_go || dbg_go;
    win_addr = core_go ? core_addr : dbg_addr;
    win_wd   = core_go ? core_wd : dbg_wd;
    // Address 0 and out-of-range addresses complete the handshake but are not written.
    addr_ok  = (win_addr != '0) && ((AW+1)'(win_addr) < (AW+1)'(NREG));
  end

  // State, clear sequencing, starvation counting and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_cnt   <= AW'(1);
      starve    <= '0;
      we3       <= 1'b0;
      a3        <= '0;
      wd3       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          we3     <= 1'b1;
          a3      <= clr_cnt;
          wd3     <= '0;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          we3 <= go && addr_ok;
          if (go) begin
            a3  <= win_addr;
            wd3 <= win_wd;
          end
          if (!dbg_valid || dbg_go) begin
            starve <= '0;
          end else if (!force_dbg) begin
            starve <= starve + SW'(1);
          end
          // The transfer accepted in this cycle still lands on this edge.
          if (clr_req) begin
            state     <= INIT;
            clr_cnt   <= AW'(1);
            starve    <= '0;
            init_done <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Self-checking bench for rf_wr_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural model of the write port.
module tb_rf_wr_ctrl;

  localparam int unsigned AW         = 5;
  localparam int unsigned DW         = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned STARVE_LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          core_valid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wd;
  logic          core_ready;
  logic          dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wd;
  logic          dbg_ready;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          init_done;

  always #5 clk = ~clk;

  rf_wr_ctrl #(.AW(AW), .DW(DW), .NREG(NREG), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .core_valid(core_valid), .core_addr(core_addr), .core_wd(core_wd), .core_ready(core_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd), .dbg_ready(dbg_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .init_done(init_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file as seen through the DUT write port.
  logic [DW-1:0] d_rf [NREG];
  always @(posedge clk) if (we3 === 1'b1 && int'(a3) < NREG) d_rf[a3] <= wd3;

  // Behavioural model: mode, next clear index, cycles debug has waited,
  // expected write-port contents and the register file contents it implies.
  bit            m_known = 1'b0;
  bit            m_run;
  int            m_clr_idx;
  int            m_wait;
  bit            e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_wd;
  bit            e_done;
  bit            a_known;
  logic [DW-1:0] m_rf [NREG];

  task automatic cycle(input bit rst, input bit clr,
                       input bit cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dv, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit rc, rd, cg, dg;
    logic [AW-1:0] wa;
    logic [DW-1:0] wdat;
    @(negedge clk);
    rst_n = ~rst; clr_req = clr;
    core_valid = cv; core_addr = ca; core_wd = cd;
    dbg_valid = dv; dbg_addr = da; dbg_wd = dd;
    #1;
    rc = 1'b0; rd = 1'b0;
    if (m_known) begin
      if (m_run) begin
        rc = (m_wait < STARVE_LIM);
        rd = (m_wait >= STARVE_LIM) || !cv;
      end
      chk("core_ready", core_ready, rc);
      chk("dbg_ready", dbg_ready, rd);
    end
    if (rst) begin
      m_known = 1'b1; m_run = 1'b0; m_clr_idx = 1; m_wait = 0;
      e_we = 1'b0; e_a = '0; e_wd = '0; e_done = 1'b0; a_known = 1'b1;
    end else if (m_known) begin
      if (!m_run) begin
        e_we = 1'b1; e_a = AW'(m_clr_idx); e_wd = '0; a_known = 1'b1;
        m_rf[m_clr_idx] = '0;
        if (m_clr_idx == NREG - 1) begin m_run = 1'b1; e_done = 1'b1; end
        m_clr_idx++;
      end else begin
        cg = cv && rc;
        dg = dv && rd;
        e_we = 1'b0;
        if (cg || dg) begin
          wa = cg ? ca : da;
          wdat = cg ? cd : dd;
          e_a = wa; e_wd = wdat;
          e_we = (wa != 0) && (int'(wa) < NREG);
          a_known = e_we;
          if (e_we) m_rf[wa] = wdat;
        end
        if (!dv || dg) m_wait = 0;
        else if (m_wait < STARVE_LIM) m_wait++;
        if (clr) begin m_run = 1'b0; m_clr_idx = 1; m_wait = 0; e_done = 1'b0; end
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("we3", we3, e_we);
      chk("init_done", init_done, e_done);
      if (a_known) begin
        chk("a3", a3, e_a);
        chk("wd3", wd3, e_wd);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin d_rf[i] = '0; m_rf[i] = '0; end
    rst_n = 1'b0; clr_req = 1'b0;
    core_valid = 1'b0; core_addr = '0; core_wd = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_wd = '0;

    // Reset, then clear sequence with no requests.
    cycle(1, 0, 0, '0, '0, 0, '0, '0);
    cycle(1, 0, 0, '0, '0, 0, '0, '0);
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    idle(30);
    chk("init_early", init_done, 0);
    idle(1);
    chk("init_at_31", init_done, 1);
    chk("last_clear_a3", a3, 31);
    idle(2);

    // Single core write.
    cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    chk("core_wr_a3", a3, 5);
    chk("core_wr_wd3", wd3, 32'hDEADBEEF);
    idle(1);
    chk("core_wr_done", we3, 0);

    // Starvation guard: core holds the port, debug wins on its 5th waiting cycle.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 5'd7, 32'h700 + i, 1, 5'd9, 32'h900 + i);
      if (i == 4) chk("starve_dbg_a3", a3, 9);
      else chk("starve_core_a3", a3, 7);
    end
    idle(1);

    // Core write to address 0 is accepted but dropped.
    cycle(0, 0, 1, 5'd0, 32'h1234, 0, '0, '0);
    chk("x0_dropped", we3, 0);
    idle(2);

    // Clear request together with a debug transfer; requesters keep asking during INIT.
    cycle(0, 1, 0, '0, '0, 1, 5'd3, 32'hCAFE0003);
    chk("clr_dbg_a3", a3, 3);
    chk("clr_done_low", init_done, 0);
    for (int i = 0; i < 31; i++) cycle(0, 0, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88);
    chk("reclear_done", init_done, 1);
    idle(2);

    // Reset asserted on the edge that would load clear address 10.
    cycle(0, 1, 0, '0, '0, 0, '0, '0);
    idle(9);
    cycle(1, 0, 0, '0, '0, 0, '0, '0);
    chk("midclr_rst_we3", we3, 0);
    chk("midclr_rst_a3", a3, 0);
    cycle(0, 0, 0, '0, '0, 0, '0, '0);
    chk("restart_a3", a3, 1);
    idle(32);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 9) < 6), AW'($urandom), $urandom,
            ($urandom_range(0, 9) < 5), AW'($urandom), $urandom);
    end
    idle(40);

    // Register contents written through the port match the model; x0 stays 0.
    chk("x0_reads_zero", d_rf[0], 0);
    for (int i = 0; i < NREG; i++) chk($sformatf("rf[%0d]", i), d_rf[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
